dp_sequencer: RTL and testbench

- Control sequencer that sits directly upstream of the 4-bit accumulator datapath.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives the datapath control lines (abus, sel_b, load_ac, add_alu) cycle by cycle.
- Captures the datapath's out_bus after the last accumulator update and returns it as a one-cycle result pulse.
- Supports load, single add, and repeated add (multi-cycle, counter-driven).

---
 rtl/dp_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dp_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dp_sequencer.sv
// rtl/dp_sequencer.sv - instruction sequencer driving the 4-bit accumulator datapath controls
// Optional feature macro: DP_SEQ_SINGLE_STEP_EN (adds the step input for single-stepping EXEC).
module dp_sequencer #(
    parameter int W  = 4,
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [1:0]    instr_op,
    input  logic [W-1:0]  instr_data,
    input  logic [CW-1:0] instr_cnt,
`ifdef DP_SEQ_SINGLE_STEP_EN
    input  logic          step,
`endif
    output logic [W-1:0]  abus,
    output logic          sel_b,
    output logic          load_ac,
    output logic          add_alu,
    input  logic [W-1:0]  out_bus,
    output logic [W-1:0]  result,
    output logic          result_valid,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, EXEC, SETTLE, DONE} state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LDA  = 2'b01;
    localparam logic [1:0] OP_ADDN = 2'b11;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  abus_q, abus_d;
    logic          sel_b_q, sel_b_d;
    logic          load_ac_q, load_ac_d;
    logic          add_alu_q, add_alu_d;
    logic [W-1:0]  result_q, result_d;
    logic          result_valid_q, result_valid_d;

    logic accept, skip, advance, exec_last, load_en;

    assign accept = instr_valid && (state_q == IDLE);
    assign skip   = (instr_op == OP_NOP) || ((instr_op == OP_ADDN) && (instr_cnt == '0));

`ifdef DP_SEQ_SINGLE_STEP_EN
    // load_ac_q is the registered step, so it marks the cycles that count as an iteration.
    assign advance = load_ac_q;
    assign load_en = step;
`else
    assign advance = 1'b1;
    assign load_en = 1'b1;
`endif

    assign exec_last = advance && (cnt_q == CW'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // LDA/ADD load a count of one so EXEC exits through the same counter test as ADDN.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = instr_op;
                    data_d  = instr_data;
                    cnt_d   = (instr_op == OP_ADDN) ? instr_cnt : CW'(1);
                    state_d = skip ? SETTLE : EXEC;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_d = SETTLE;
                end else if (advance) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SETTLE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Controls are registered one edge ahead, so they are computed from where the FSM is going.
    always_comb begin
        logic       drive;
        logic [1:0] drv_op;
        logic [W-1:0] drv_data;
        drive          = 1'b0;
        drv_op         = op_q;
        drv_data       = data_q;
        abus_d         = '0;
        sel_b_d        = 1'b0;
        load_ac_d      = 1'b0;
        add_alu_d      = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        if ((state_q == IDLE) && accept && !skip) begin
            drive    = 1'b1;
            drv_op   = instr_op;
            drv_data = instr_data;
        end else if ((state_q == EXEC) && !exec_last) begin
            drive = 1'b1;
        end
        if (drive) begin
            abus_d    = drv_data;
            sel_b_d   = (drv_op != OP_LDA);
            add_alu_d = (drv_op != OP_LDA);
            load_ac_d = load_en;
        end
        if (state_q == SETTLE) begin
            result_d       = out_bus;
            result_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q           <= OP_NOP;
            data_q         <= '0;
            cnt_q          <= '0;
            abus_q         <= '0;
            sel_b_q        <= 1'b0;
            load_ac_q      <= 1'b0;
            add_alu_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            op_q           <= op_d;
            data_q         <= data_d;
            cnt_q          <= cnt_d;
            abus_q         <= abus_d;
            sel_b_q        <= sel_b_d;
            load_ac_q      <= load_ac_d;
            add_alu_q      <= add_alu_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign instr_ready  = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign abus         = abus_q;
    assign sel_b        = sel_b_q;
    assign load_ac      = load_ac_q;
    assign add_alu      = add_alu_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// tb/tb_dp_sequencer.sv - scoreboard bench for dp_sequencer with an accumulator datapath stub
module tb_dp_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_op = 2'b00;
    logic [3:0] instr_data = 4'h0;
    logic [3:0] instr_cnt = 4'h0;
    logic [3:0] abus;
    logic       sel_b, load_ac, add_alu;
    logic [3:0] out_bus;
    logic [3:0] result;
    logic       result_valid, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ld_cnt = 0;

    typedef struct {
        logic [3:0] res;
        int         at_cyc;
        int         loads;
    } exp_t;
    exp_t sb[$];

    // Accumulator datapath stub: B = A bus or accumulator, ALU adds A + B.
    logic [3:0] ac = 4'h0;
    assign out_bus = ac;
    always @(posedge clock) begin
        if (load_ac) ac <= add_alu ? ac + abus : abus;
    end

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dp_sequencer #(.W(4), .CW(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_data(instr_data), .instr_cnt(instr_cnt),
`ifdef DP_SEQ_SINGLE_STEP_EN
        .step(1'b1),
`endif
        .abus(abus), .sel_b(sel_b), .load_ac(load_ac), .add_alu(add_alu),
        .out_bus(out_bus), .result(result), .result_valid(result_valid), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: each result pulse must match the oldest pending instruction.
    always @(negedge clock) begin
        if (!reset_n) begin
            ld_cnt = 0;
        end else begin
            if (load_ac) ld_cnt++;
            if (result_valid) begin
                check("result_expected", 32'(sb.size() != 0), 32'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_value", 32'(result), 32'(e.res));
                    check("result_cycle", 32'(cyc), 32'(e.at_cyc));
                    check("load_count", 32'(ld_cnt), 32'(e.loads));
                end
                ld_cnt = 0;
            end
        end
    end

    // Drives an instruction at a negedge, waits for acceptance; returns at the negedge of cycle T.
    task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [3:0] cnt,
                         input logic push, input logic [3:0] res, input int lat, input int loads,
                         input logic hold, output int t_acc);
        int waited;
        exp_t e;
        instr_op    = op;
        instr_data  = data;
        instr_cnt   = cnt;
        instr_valid = 1'b1;
        waited      = 0;
        while (!instr_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check("accept_timeout", 32'(instr_ready), 32'(1));
        t_acc = cyc + 1;
        if (push) begin
            e.res = res; e.at_cyc = t_acc + lat - 1; e.loads = loads;
            sb.push_back(e);
        end
        @(negedge clock);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t, t2;
        #1;
        check("rst_abus", 32'(abus), 32'(0));
        check("rst_ctrl", 32'({sel_b, load_ac, add_alu}), 32'(0));
        check("rst_result", 32'({result, result_valid}), 32'(0));
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(instr_ready), 32'(1));
        check("busy_after_rst", 32'(busy), 32'(0));
        @(negedge clock);

        issue(2'b01, 4'hF, 4'h0, 1'b1, 4'hF, 3, 1, 1'b0, t);
        check("lda_ctrl", 32'({abus, sel_b, add_alu, load_ac}), 32'({4'hF, 1'b0, 1'b0, 1'b1}));
        check("lda_busy", 32'({busy, instr_ready}), 32'(2'b10));
        @(negedge clock);
        check("lda_ctrl_off", 32'({abus, sel_b, add_alu, load_ac}), 32'(0));

        issue(2'b10, 4'h6, 4'h0, 1'b1, 4'h5, 3, 1, 1'b0, t);
        check("add_ctrl", 32'({abus, sel_b, add_alu, load_ac}), 32'({4'h6, 1'b1, 1'b1, 1'b1}));
        @(negedge clock);
        check("add_ctrl_off", 32'({abus, sel_b, add_alu, load_ac}), 32'(0));

        issue(2'b11, 4'h3, 4'h4, 1'b1, 4'h1, 6, 4, 1'b0, t);
        issue(2'b11, 4'h7, 4'h0, 1'b1, 4'h1, 2, 0, 1'b0, t);
        issue(2'b00, 4'h9, 4'h5, 1'b1, 4'h1, 2, 0, 1'b0, t);
        issue(2'b11, 4'h2, 4'hF, 1'b1, 4'hF, 17, 15, 1'b0, t);
        drain();

        issue(2'b11, 4'h1, 4'h8, 1'b0, 4'h0, 0, 0, 1'b0, t);
        repeat (2) @(negedge clock);
        check("addn_mid_load", 32'(load_ac), 32'(1));
        reset_n = 1'b0;
        #1;
        check("abort_ctrl", 32'({abus, sel_b, add_alu, load_ac}), 32'(0));
        check("abort_result", 32'({result, result_valid}), 32'(0));
        check("abort_busy", 32'({busy, instr_ready}), 32'(2'b01));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("abort_ready", 32'(instr_ready), 32'(1));
        repeat (20) @(negedge clock);

        issue(2'b01, 4'hF, 4'h0, 1'b1, 4'hF, 3, 1, 1'b1, t);
        check("b2b_ready_t", 32'(instr_ready), 32'(0));
        @(negedge clock);
        check("b2b_ready_settle", 32'(instr_ready), 32'(0));
        @(negedge clock);
        check("b2b_ready_done", 32'(instr_ready), 32'(0));
        issue(2'b01, 4'h6, 4'h0, 1'b1, 4'h6, 3, 1, 1'b0, t2);
        check("b2b_second_accept", 32'(t2 - t), 32'(4));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
